// File: rtl/shufflebias_pool_if.sv
`default_nettype none
// ============================================================================
// shufflebias_pool_if : control, per-row read and status bundle for shufflebias_pool.
// Rev 1.0
// ============================================================================
`ifndef GRID_LEN
`define GRID_LEN 4
`endif

interface shufflebias_pool_if #(
  parameter int W    = `GRID_LEN,
  parameter int ROWS = `GRID_LEN
);
  logic                     reshuffle;
  logic                     seed_load;
  logic [15:0]              seed;
  logic                     ready;
  logic [ROWS-1:0]          update;
  logic [ROWS*(W+1)-1:0]    rqindex;
  logic [ROWS*W-1:0]        busvalue;
  logic                     perm_error;

  modport master (
    output reshuffle, seed_load, seed, update, rqindex,
    input  ready, busvalue, perm_error
  );

  modport slave (
    input  reshuffle, seed_load, seed, update, rqindex,
    output ready, busvalue, perm_error
  );
endinterface

`default_nettype wire

// File: rtl/shufflebias_pool.sv
`default_nettype none
// ============================================================================
// shufflebias_pool : ROWS LFSR-driven Fisher-Yates one-hot pools, registered per-row bias buses.
// Optional permutation checker built when SHUFFLEBIAS_CHECK_EN is defined.   Rev 1.0
// ============================================================================
`ifndef GRID_LEN
`define GRID_LEN 4
`endif

module shufflebias_pool #(
  parameter int          W    = `GRID_LEN,
  parameter int          ROWS = `GRID_LEN,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic               clock,
  input logic               reset,
  shufflebias_pool_if.slave bus
);

  localparam int          L      = $clog2(W);
  localparam int          LW     = (L < 1) ? 1 : L;
  localparam int          RW     = (ROWS < 2) ? 1 : $clog2(ROWS);
  localparam logic [15:0] TAPS   = 16'hB400;
  localparam logic [LW-1:0] I_TOP  = LW'(W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);

  typedef enum logic [0:0] {
    ST_SHUFFLE = 1'b0,
    ST_IDLE    = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q,   row_d;
  logic [LW-1:0]   idx_q,   idx_d;
  logic [15:0]     lfsr_q,  lfsr_d;
  logic [W-1:0]    pool_q [ROWS][W];
  logic [W-1:0]    pool_d [ROWS][W];

  logic [15:0]     lfsr_step;
  logic [LW-1:0]   draw;
  logic            pools_ready;

  assign lfsr_step   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
  assign draw        = lfsr_q[LW-1:0];
  assign pools_ready = (state_q == ST_IDLE);
  assign bus.ready   = pools_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_SHUFFLE;
      row_q   <= '0;
      idx_q   <= I_TOP;
      lfsr_q  <= SEED;
      for (int r = 0; r < ROWS; r++) begin
        for (int k = 0; k < W; k++) begin
          pool_q[r][k] <= W'(1) << k;
        end
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      pool_q  <= pool_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    pool_d  = pool_q;
    case (state_q)
      ST_SHUFFLE: begin
        lfsr_d = lfsr_step;
        if (W < 2) begin
          state_d = ST_IDLE;
        end else if (draw <= idx_q) begin
          // Out-of-range draws are rejected and retried so every slot stays uniform.
          pool_d[row_q][idx_q] = pool_q[row_q][draw];
          pool_d[row_q][draw]  = pool_q[row_q][idx_q];
          if (idx_q == LW'(1)) begin
            if (row_q == R_LAST) begin
              state_d = ST_IDLE;
            end else begin
              row_d = row_q + 1'b1;
              idx_d = I_TOP;
            end
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      default: begin
        if (bus.seed_load) begin
          lfsr_d = (bus.seed == 16'h0000) ? SEED : bus.seed;
        end
        if (bus.reshuffle) begin
          state_d = ST_SHUFFLE;
          row_d   = '0;
          idx_d   = I_TOP;
        end
      end
    endcase
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    logic [W-1:0] val_q, val_d;

    always_comb begin
      val_d = '0;
      for (int k = 0; k < W; k++) begin
        if (bus.rqindex[gr*(W+1) + k]) begin
          val_d = val_d | pool_q[gr][k];
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        val_q <= '0;
      end else if (bus.update[gr] && pools_ready) begin
        val_q <= val_d;
      end
    end

    assign bus.busvalue[gr*W +: W] = val_q;
  end

`ifdef SHUFFLEBIAS_CHECK_EN
  logic         perm_err_q;
  logic         perm_bad;
  logic [W-1:0] cover_acc;

  always_comb begin
    perm_bad  = 1'b0;
    cover_acc = '0;
    for (int r = 0; r < ROWS; r++) begin
      cover_acc = '0;
      for (int k = 0; k < W; k++) begin
        cover_acc = cover_acc | pool_q[r][k];
        if ((pool_q[r][k] == '0) || ((pool_q[r][k] & (pool_q[r][k] - 1'b1)) != '0)) begin
          perm_bad = 1'b1;
        end
      end
      if (cover_acc != '1) begin
        perm_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perm_err_q <= 1'b0;
    end else if (perm_bad) begin
      perm_err_q <= 1'b1;
    end
  end

  assign bus.perm_error = perm_err_q;
`else
  assign bus.perm_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shufflebias_pool.sv
`default_nettype none
// tb_shufflebias_pool: directed checks of a W=4/ROWS=1 pool against hand-derived
// shuffle results, plus a W=9/ROWS=9 pool checked for length and permutation shape.
module tb_shufflebias_pool;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  shufflebias_pool_if #(.W(4), .ROWS(1)) ifa ();
  shufflebias_pool_if #(.W(9), .ROWS(9)) ifb ();

  shufflebias_pool #(.W(4), .ROWS(1)) u_a (
    .clock (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  shufflebias_pool #(.W(9), .ROWS(9)) u_b (
    .clock (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a(input int bound, output int cycles);
    cycles = 0;
    while (ifa.ready !== 1'b1 && cycles < bound) begin
      tick();
      cycles++;
    end
  endtask

  task automatic read_a(input string tag, input logic [4:0] idx, input logic [3:0] exp);
    ifa.rqindex = idx;
    ifa.update  = 1'b1;
    tick();
    ifa.update  = 1'b0;
    check_val(tag, {28'h0, ifa.busvalue}, {28'h0, exp});
  endtask

  task automatic check_pool_a(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                              input logic [3:0] e2, input logic [3:0] e3);
    read_a({tag, "_k0"}, 5'b00001, e0);
    read_a({tag, "_k1"}, 5'b00010, e1);
    read_a({tag, "_k2"}, 5'b00100, e2);
    read_a({tag, "_k3"}, 5'b01000, e3);
  endtask

  task automatic request_a(input logic ld, input logic [15:0] sd);
    ifa.seed_load = ld;
    ifa.seed      = sd;
    ifa.reshuffle = 1'b1;
    tick();
    ifa.seed_load = 1'b0;
    ifa.reshuffle = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc;
    int          cyc_b;
    logic        perm_seen;
    logic [8:0]  val;
    logic [8:0]  acc [9];

    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.reshuffle = 1'b0; ifa.seed_load = 1'b0; ifa.seed = '0; ifa.update = '0; ifa.rqindex = '0;
    ifb.reshuffle = 1'b0; ifb.seed_load = 1'b0; ifb.seed = '0; ifb.update = '0; ifb.rqindex = '0;
    tick();
    tick();
    check_val("rst_ready", {31'h0, ifa.ready}, 32'd0);
    check_val("rst_bus", {28'h0, ifa.busvalue}, 32'd0);
    check_val("rst_perm", {31'h0, ifa.perm_error}, 32'd0);

    // Reset release: 3 steps from SEED, no rejections; read and reshuffle ignored meanwhile
    rst_a = 1'b0;
    tick();
    check_val("busy_ready1", {31'h0, ifa.ready}, 32'd0);
    ifa.reshuffle = 1'b1;
    ifa.update    = 1'b1;
    ifa.rqindex   = 5'b00001;
    tick();
    ifa.reshuffle = 1'b0;
    ifa.update    = 1'b0;
    check_val("busy_ready2", {31'h0, ifa.ready}, 32'd0);
    check_val("busy_bus", {28'h0, ifa.busvalue}, 32'd0);
    tick();
    check_val("ready_rise", {31'h0, ifa.ready}, 32'd1);
    repeat (4) tick();
    check_val("ready_hold", {31'h0, ifa.ready}, 32'd1);

    check_pool_a("post_rst", 4'h8, 4'h4, 4'h1, 4'h2);
    read_a("multi_hot", 5'b00011, 4'hC);
    read_a("zero_entry", 5'b10000, 4'h0);
    read_a("multi_all", 5'b01111, 4'hF);
    read_a("idx_none", 5'b00000, 4'h0);

    // Seed 1234 with reshuffle; simultaneous read sees the pre-shuffle pool
    ifa.update  = 1'b1;
    ifa.rqindex = 5'b00001;
    request_a(1'b1, 16'h1234);
    ifa.update  = 1'b0;
    check_val("pre_shuffle_read", {28'h0, ifa.busvalue}, 32'h8);
    check_val("reshuf_busy", {31'h0, ifa.ready}, 32'd0);
    wait_ready_a(50, cyc);
    check_val("reshuf_len", cyc, 32'd3);
    check_pool_a("seed1234", 4'h2, 4'h4, 4'h1, 4'h8);

    // Determinism across reset
    rst_a = 1'b1;
    tick();
    check_val("rst2_bus", {28'h0, ifa.busvalue}, 32'd0);
    rst_a = 1'b0;
    wait_ready_a(50, cyc);
    check_val("rst2_len", cyc, 32'd3);
    request_a(1'b1, 16'h1234);
    wait_ready_a(50, cyc);
    check_pool_a("determ", 4'h2, 4'h4, 4'h1, 4'h8);

    // Zero seed loads SEED
    request_a(1'b1, 16'h0000);
    wait_ready_a(50, cyc);
    check_val("seed0_len", cyc, 32'd3);
    check_pool_a("seed0", 4'h8, 4'h1, 4'h2, 4'h4);

    // Reset mid-shuffle restarts from identity
    request_a(1'b0, 16'h0000);
    tick();
    tick();
    rst_a = 1'b1;
    #1;
    check_val("mid_rst_bus", {28'h0, ifa.busvalue}, 32'd0);
    check_val("mid_rst_ready", {31'h0, ifa.ready}, 32'd0);
    tick();
    rst_a = 1'b0;
    wait_ready_a(50, cyc);
    check_val("mid_rst_len", cyc, 32'd3);
    check_pool_a("mid_rst", 4'h8, 4'h4, 4'h1, 4'h2);

    // Reshuffle from held LFSR 389C: two rejected draws; seed_load mid-shuffle ignored
    request_a(1'b0, 16'h0000);
    ifa.seed_load = 1'b1;
    ifa.seed      = 16'h1234;
    tick();
    ifa.seed_load = 1'b0;
    wait_ready_a(50, cyc);
    check_val("reject_len", cyc + 1, 32'd5);
    check_pool_a("reject", 4'h2, 4'h4, 4'h1, 4'h8);
    check_val("a_perm", {31'h0, ifa.perm_error}, 32'd0);

    // Wide instance: W=9 forces rejections, nine rows
    rst_b     = 1'b0;
    cyc_b     = 0;
    perm_seen = 1'b0;
    while (ifb.ready !== 1'b1 && cyc_b < 3000) begin
      tick();
      cyc_b++;
      if (ifb.perm_error !== 1'b0) perm_seen = 1'b1;
    end
    check_val("b_done", {31'h0, ifb.ready}, 32'd1);
    check_val("b_len_min", {31'h0, (cyc_b >= 72)}, 32'd1);
    check_val("b_perm", {31'h0, perm_seen}, 32'd0);

    for (int r = 0; r < 9; r++) acc[r] = '0;
    for (int k = 0; k <= 9; k++) begin
      ifb.rqindex = '0;
      for (int r = 0; r < 9; r++) ifb.rqindex[r*10 + k] = 1'b1;
      ifb.update = '1;
      tick();
      ifb.update = '0;
      for (int r = 0; r < 9; r++) begin
        val = ifb.busvalue[r*9 +: 9];
        if (k < 9) begin
          check_val($sformatf("b_onehot_r%0d_k%0d", r, k), {31'h0, ($countones(val) == 1)}, 32'd1);
          acc[r] = acc[r] | val;
        end else begin
          check_val($sformatf("b_zero_r%0d", r), {23'h0, val}, 32'd0);
        end
      end
    end
    for (int r = 0; r < 9; r++) begin
      check_val($sformatf("b_cover_r%0d", r), {23'h0, acc[r]}, 32'h1FF);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shufflebias_pool.md
Name: shufflebias_pool

Overview:
- Successor to the single-row row-bias bus.
- Holds ROWS independent shuffle pools. Each pool is a random permutation of the W one-hot values, plus a fixed all-zero entry at index W.
- An on-chip LFSR drives a Fisher-Yates shuffle, one swap per cycle. The shuffle runs after every reset and on request.
- Each row has its own registered bias bus, updated by one-hot (or multi-hot) index, feeding all tiles of that row in the solver grid.

Parameters:
- W, `GRID_LEN: value width; each pool has W shufflable one-hot entries plus one zero entry.
- ROWS, `GRID_LEN: number of independent row channels.
- SEED, 16'hACE1: LFSR value after reset; also used when a zero seed is loaded.
- L, $clog2(W): draw width taken from the LFSR (derived; not overridden).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- reshuffle  in  1  one-cycle request to reshuffle all pools.
- seed_load  in  1  load the LFSR from seed.
- seed  in  16  new LFSR value.
- ready  out  1  high when pools are stable and reads are accepted.
- update  in  ROWS  per-row read strobe.
- rqindex  in  ROWS*(W+1)  per-row index; row r occupies bits [r*(W+1) +: W+1].
- busvalue  out  ROWS*W  per-row bias value; row r occupies bits [r*W +: W].
- perm_error  out  1  permutation check flag (see Optional Feature).

Behaviour:
- Reset (async, active-high):
  - every pool entry pool[r][k] = 1<<k for k<W;
  - LFSR = SEED; busvalue = 0; ready = 0; state = SHUFFLE with r=0, i=W-1.
- Leaving reset, the first rising edge performs the first shuffle step. A reset assertion mid-shuffle aborts the shuffle and restarts it from identity.
- LFSR: 16-bit Galois, taps 16'hB400, shifts right. It advances on every clock in SHUFFLE and holds in IDLE.
- State SHUFFLE (ready = 0), one step per cycle:
  - draw = LFSR[L-1:0].
  - If draw <= i: swap pool[r][i] with pool[r][draw] (draw == i is a no-op swap), then i <= i-1.
  - Else: reject; no swap, i unchanged, retry next cycle.
  - When the step at i=1 is accepted: if r == ROWS-1, go to IDLE and set ready = 1 from the next cycle; else r <= r+1, i <= W-1.
  - Minimum shuffle length is ROWS*(W-1) cycles; rejection adds cycles. W=1 degenerates to zero steps: go straight to IDLE.
- State IDLE (ready = 1):
  - reshuffle = 1: go to SHUFFLE, r=0, i=W-1. The shuffle starts from the current pool contents, not from identity.
  - seed_load = 1: LFSR <= (seed == 0) ? SEED : seed.
  - Both reshuffle and seed_load in the same cycle: the seed loads and the shuffle's first step uses the new seed.
  - seed_load and reshuffle asserted during SHUFFLE are ignored.
- Read path, per row r:
  - If update[r] && ready: busvalue[r] <= OR over k<W of (rqindex[r][k] ? pool[r][k] : 0). Bit W selects zero.
  - Multi-hot index: the OR of the selected entries (defined behaviour). All-zero index gives 0.
  - update while ready = 0 is ignored; busvalue holds.
  - One-cycle latency: the value appears on the rising edge that samples update.
  - A read in the same cycle that reshuffle is accepted uses the pre-shuffle pool.
- Every pool is a permutation of {1<<k} at all times, including mid-shuffle.

Optional Feature:
- SHUFFLEBIAS_CHECK_EN defined:
  - perm_error is registered; it is set when, for any row, the OR of pool entries != all-ones or any entry is not one-hot.
  - Once set, it stays set until reset.
  - Reset value 0.
- Undefined: perm_error is tied to 0 and no checker logic is built.

Test Plan:
- Reset release, W=4, ROWS=1: ready stays 0 for ≥3 cycles, then rises. Every update with rqindex=5'b00001/00010/00100/01000 returns a distinct one-hot value; their OR is 4'b1111.
- Zero entry: ready=1, rqindex=5'b10000, update=1 -> busvalue=4'b0000 next cycle. Multi-hot 5'b00011 -> OR of entries 0 and 1 (two bits set).
- Determinism: seed_load with seed=16'h1234, reshuffle, record pools; reset, repeat the same sequence -> identical pools. seed=0 behaves as SEED.
- Busy gating: update during SHUFFLE -> busvalue unchanged. reshuffle during SHUFFLE -> no extra shuffle; ready rises once.
- Rejection: W=9 (L=4), ROWS=9: shuffle takes ≥72 cycles; all nine rows are permutations. With the check macro defined, perm_error=0 throughout.
- Reset mid-shuffle after 5 cycles -> busvalue=0, ready=0; the shuffle restarts from identity with SEED and produces the same result as the post-reset case.
